// File: rtl/systolic_sequencer_if.sv
// Host/array signal bundle for systolic_sequencer.
// master = sequencer side, slave = host pins plus array instance.
interface systolic_sequencer_if #(
    parameter int N = 8
);
    logic         start;
    logic [7:0]   k_len;
    logic         mode_xor;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         arr_clear;
    logic         arr_in_valid;
    logic         arr_readout;
    logic         arr_usexor;
    logic [N-1:0] arr_in1;
    logic [N-1:0] arr_in2;
    logic [N-1:0] arr_out;

    modport master (
        input  start, k_len, mode_xor, in_valid, in_a, in_b, out_ready, arr_out,
        output in_ready, out_valid, out_data, out_last, busy, done,
               arr_clear, arr_in_valid, arr_readout, arr_usexor, arr_in1, arr_in2
    );

    modport slave (
        output start, k_len, mode_xor, in_valid, in_a, in_b, out_ready, arr_out,
        input  in_ready, out_valid, out_data, out_last, busy, done,
               arr_clear, arr_in_valid, arr_readout, arr_usexor, arr_in1, arr_in2
    );
endinterface

// File: rtl/systolic_sequencer.sv
// Runs one clear/load/drain/readout job on the N x N bit systolic array.
// SEQ_SKEW_EN adds a diagonal skew stage on the operand buses and lengthens the drain by N-1.
module systolic_sequencer #(
    parameter int N     = 8,
    parameter int DRAIN = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_sequencer_if.master bus
);
`ifdef SEQ_SKEW_EN
    localparam int DRAIN_EFF = DRAIN + N - 1;
`else
    localparam int DRAIN_EFF = DRAIN;
`endif
    localparam int DW = $clog2(DRAIN_EFF + 1);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_DRAIN, S_PRIME, S_READ, S_WAIT
    } state_t;

    state_t        r_state;
    logic [7:0]    r_k;
    logic [7:0]    r_pair_cnt;
    logic [DW-1:0] r_drain_cnt;
    logic [RW-1:0] r_row;
    logic          r_out_valid;
    logic          r_out_last;
    logic [N-1:0]  r_out_data;
    logic          r_busy;
    logic          r_done;
    logic          r_arr_clear;
    logic          r_arr_in_valid;
    logic          r_arr_usexor;
    logic [N-1:0]  r_op1;
    logic [N-1:0]  r_op2;

    logic w_in_ready;
    logic w_accept;
    logic w_rd_fire;

    // in_ready is decoded from the count so it falls right after the k-th handshake.
    assign w_in_ready = (r_state == S_LOAD) && (r_pair_cnt != r_k);
    assign w_accept   = w_in_ready && bus.in_valid;
    assign w_rd_fire  = (r_state == S_READ) && (!r_out_valid || bus.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_k            <= 8'd0;
            r_pair_cnt     <= 8'd0;
            r_drain_cnt    <= '0;
            r_row          <= '0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_out_data     <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_arr_clear    <= 1'b0;
            r_arr_in_valid <= 1'b0;
            r_arr_usexor   <= 1'b0;
            r_op1          <= '0;
            r_op2          <= '0;
        end else begin
            // Strobes and operand buses idle at zero unless a state drives them.
            r_arr_clear    <= 1'b0;
            r_arr_in_valid <= 1'b0;
            r_op1          <= '0;
            r_op2          <= '0;
            r_done         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_k          <= (bus.k_len == 8'd0) ? 8'd1 : bus.k_len;
                        r_arr_usexor <= bus.mode_xor;
                        r_pair_cnt   <= 8'd0;
                        r_arr_clear  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_CLEAR;
                    end
                end
                S_CLEAR: r_state <= S_LOAD;
                S_LOAD: begin
                    if (w_accept) begin
                        r_op1          <= bus.in_a;
                        r_op2          <= bus.in_b;
                        r_arr_in_valid <= 1'b1;
                        r_pair_cnt     <= r_pair_cnt + 8'd1;
                        if (r_pair_cnt + 8'd1 == r_k) begin
                            r_drain_cnt <= '0;
                            r_state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // First DRAIN cycle presents the last pair; DRAIN_EFF zero strobes follow.
                    if (r_drain_cnt == DW'(DRAIN_EFF)) begin
                        r_state <= S_PRIME;
                    end else begin
                        r_arr_in_valid <= 1'b1;
                        r_drain_cnt    <= r_drain_cnt + DW'(1);
                    end
                end
                S_PRIME: begin
                    r_row   <= '0;
                    r_state <= S_READ;
                end
                S_READ: begin
                    if (w_rd_fire) begin
                        r_out_data  <= bus.arr_out;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_row == RW'(N - 1));
                        if (r_row == RW'(N - 1)) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_row <= r_row + RW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_last     = r_out_last;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.arr_clear    = r_arr_clear;
    assign bus.arr_in_valid = r_arr_in_valid;
    // Readout depends on out_ready this cycle, so a held output never drops a row.
    assign bus.arr_readout  = (r_state == S_PRIME) || w_rd_fire;
    assign bus.arr_usexor   = r_arr_usexor;

`ifdef SEQ_SKEW_EN
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        if (gi == 0) begin : g_direct
            assign bus.arr_in1[gi] = r_op1[gi];
            assign bus.arr_in2[gi] = r_op2[gi];
        end else begin : g_delay
            logic r_sr1 [gi];
            logic r_sr2 [gi];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < gi; s++) begin
                        r_sr1[s] <= 1'b0;
                        r_sr2[s] <= 1'b0;
                    end
                end else if (r_arr_in_valid) begin
                    r_sr1[0] <= r_op1[gi];
                    r_sr2[0] <= r_op2[gi];
                    for (int s = 1; s < gi; s++) begin
                        r_sr1[s] <= r_sr1[s-1];
                        r_sr2[s] <= r_sr2[s-1];
                    end
                end
            end
            assign bus.arr_in1[gi] = r_arr_in_valid & r_sr1[gi-1];
            assign bus.arr_in2[gi] = r_arr_in_valid & r_sr2[gi-1];
        end
    end
`else
    assign bus.arr_in1 = r_op1;
    assign bus.arr_in2 = r_op2;
`endif
endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomized bench for systolic_sequencer with a behavioural bit-array stub and row reference model.
// Row r of the stub array is the OR/XOR over accepted pairs of (in1[r] ? in2 : 0).
module tb_systolic_sequencer;
    localparam int N     = 8;
    localparam int DRAIN = 14;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    systolic_sequencer_if #(.N(N)) bus_if ();

    systolic_sequencer #(.N(N), .DRAIN(DRAIN)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural array stub: accumulate on arr_in_valid, snapshot on first readout, then shift rows out.
    logic [7:0] st_acc [8];
    logic [7:0] st_sh  [8];
    bit         st_loaded;
    int         st_ptr;

    always @(posedge clk) begin
        if (bus_if.arr_clear) begin
            for (int i = 0; i < N; i++) st_acc[i] <= 8'h00;
            st_loaded <= 1'b0;
        end else if (bus_if.arr_in_valid) begin
            for (int i = 0; i < N; i++)
                if (bus_if.arr_in1[i])
                    st_acc[i] <= bus_if.arr_usexor ? (st_acc[i] ^ bus_if.arr_in2) : (st_acc[i] | bus_if.arr_in2);
        end
        if (bus_if.arr_readout) begin
            if (!st_loaded) begin
                st_sh     <= st_acc;
                st_ptr    <= 0;
                st_loaded <= 1'b1;
            end else begin
                st_ptr <= st_ptr + 1;
            end
        end
    end

    assign bus_if.arr_out = (st_loaded && st_ptr < N) ? st_sh[st_ptr[2:0]] : 8'h00;

    // Protocol monitor, sampled on the active edge before registers update.
    int mon_clear, mon_valid, mon_readout, mon_zero_bad, mon_hold_bad;
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus_if.arr_clear)    mon_clear   <= mon_clear + 1;
            if (bus_if.arr_in_valid) mon_valid   <= mon_valid + 1;
            if (bus_if.arr_readout)  mon_readout <= mon_readout + 1;
            if (!bus_if.arr_in_valid && (bus_if.arr_in1 != 8'h00 || bus_if.arr_in2 != 8'h00))
                mon_zero_bad <= mon_zero_bad + 1;
            if (bus_if.arr_readout && bus_if.out_valid && !bus_if.out_ready)
                mon_hold_bad <= mon_hold_bad + 1;
        end
    end

    logic [32:0] all_outs;
    assign all_outs = {bus_if.in_ready, bus_if.out_valid, bus_if.out_data, bus_if.out_last,
                       bus_if.busy, bus_if.done, bus_if.arr_clear, bus_if.arr_in_valid,
                       bus_if.arr_readout, bus_if.arr_usexor, bus_if.arr_in1, bus_if.arr_in2};

    logic [7:0] pa [$];
    logic [7:0] pb [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_row(input int r, input bit x);
        logic [7:0] v;
        v = 8'h00;
        for (int p = 0; p < pa.size(); p++)
            if (pa[p][r]) v = x ? (v ^ pb[p]) : (v | pb[p]);
        return v;
    endfunction

    task automatic run_job(input logic [7:0] k, input bit x, input int rpat,
                           input bit fixed, input logic [7:0] fa, input logic [7:0] fb,
                           input bit poke_load, input bit poke_read);
        int         keff, c0, v0, r0, z0, h0, got, budget, ph, extra;
        bit         poked_l, poked_r;
        logic [7:0] lastmask;
        logic [7:0] rows [8];
        keff = (k == 8'd0) ? 1 : int'(k);
        pa.delete();
        pb.delete();
        c0 = mon_clear; v0 = mon_valid; r0 = mon_readout; z0 = mon_zero_bad; h0 = mon_hold_bad;
        poked_l = 1'b0; poked_r = 1'b0;

        @(negedge clk);
        bus_if.start = 1'b1; bus_if.k_len = k; bus_if.mode_xor = x;
        @(negedge clk);
        bus_if.start = 1'b0; bus_if.k_len = 8'($urandom); bus_if.mode_xor = 1'($urandom);
        chk("busy_after_start", bus_if.busy, 1);

        budget = 0;
        while (pa.size() < keff && budget < 500) begin
            bus_if.in_valid = ($urandom_range(0, 3) != 0);
            bus_if.in_a = fixed ? fa : 8'($urandom);
            bus_if.in_b = fixed ? fb : 8'($urandom);
            if (poke_load && !poked_l && pa.size() == 1) begin
                bus_if.start = 1'b1; bus_if.k_len = 8'd9; bus_if.mode_xor = ~x; poked_l = 1'b1;
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
                pa.push_back(bus_if.in_a);
                pb.push_back(bus_if.in_b);
            end
            @(negedge clk);
            bus_if.start = 1'b0;
            budget++;
        end
        chk("pairs_accepted", pa.size(), keff);

        extra = 0;
        for (int i = 0; i < 3; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_a = 8'($urandom);
            bus_if.in_b = 8'($urandom);
            if (bus_if.in_ready) extra++;
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
        chk("no_extra_pair", extra, 0);

        got = 0; lastmask = 8'h00; budget = 0; ph = 0;
        while (got < N && budget < 400) begin
            case (rpat)
                0:       bus_if.out_ready = 1'b1;
                1:       bus_if.out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                default: bus_if.out_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
            if (poke_read && !poked_r && got == 3) begin
                bus_if.start = 1'b1; bus_if.k_len = 8'd3; bus_if.mode_xor = ~x; poked_r = 1'b1;
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                rows[got] = bus_if.out_data;
                if (bus_if.out_last) lastmask[got] = 1'b1;
                got++;
            end
            @(negedge clk);
            bus_if.start = 1'b0;
            budget++;
        end
        chk("rows_delivered", got, N);
        chk("done_pulse", bus_if.done, 1);
        chk("busy_low_at_done", bus_if.busy, 0);
        chk("out_valid_cleared", bus_if.out_valid, 0);
        bus_if.out_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", bus_if.done, 0);

        for (int r = 0; r < got; r++)
            chk($sformatf("row%0d", r), rows[r], ref_row(r, x));
        chk("out_last_only_row7", lastmask, 8'h80);
        chk("usexor_latched", bus_if.arr_usexor, x);
        chk("clear_pulses", mon_clear - c0, 1);
        chk("valid_strobes", mon_valid - v0, keff + DRAIN);
        chk("readout_strobes", mon_readout - r0, N + 1);
        chk("operand_zero_when_idle", mon_zero_bad - z0, 0);
        chk("readout_held_low", mon_hold_bad - h0, 0);
        $display("job k=%0d mode=%0d pat=%0d pairs=%0d rows=%0d", k, x, rpat, pa.size(), got);
    endtask

    initial begin
        int acc, budget;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.start = 1'b0; bus_if.k_len = 8'd0; bus_if.mode_xor = 1'b0;
        bus_if.in_valid = 1'b0; bus_if.in_a = 8'h00; bus_if.in_b = 8'h00;
        bus_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs, 0);
        rst_n = 1'b1;

        // Reset mid-LOAD after two of four pairs.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.k_len = 8'd4; bus_if.mode_xor = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        acc = 0; budget = 0;
        while (acc < 2 && budget < 50) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_a = 8'($urandom);
            bus_if.in_b = 8'($urandom);
            if (bus_if.in_ready) acc++;
            @(negedge clk);
            budget++;
        end
        bus_if.in_valid = 1'b0;
        chk("midload_pairs", acc, 2);
        rst_n = 1'b0;
        #1;
        chk("midjob_reset_outputs", all_outs, 0);
        chk("midjob_reset_busy", bus_if.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(8'd3, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        run_job(8'd1, 1'b0, 0, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        run_job(8'd2, 1'b1, 0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0);
        run_job(8'd0, 1'b1, 2, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        run_job(8'd6, 1'b0, 1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        run_job(8'd5, 1'b1, 2, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        for (int j = 0; j < 3; j++)
            run_job(8'($urandom_range(1, 12)), 1'($urandom), int'($urandom_range(0, 2)),
                    1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/systolic_sequencer.md
Name: systolic_sequencer

Overview:
- Controller that runs one full accumulate-then-readout job on the N x N bit systolic array.
- Host side: a start command plus valid/ready operand and result streams.
- Array side: drives the operand buses, valid/readout/clear strobes and the OR/XOR mode; collects readout rows.
- Sits between top-level pin logic and the systolic_array instance.

Parameters:
- N, 8, array dimension and operand/result width in bits.
- DRAIN, 14, zero-operand flush cycles after the last pair (2N-2 for N=8).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request pulse; sampled only in IDLE
- k_len  in  8  operand pairs per job; 0 treated as 1
- mode_xor  in  1  accumulate mode latched at start; 1=XOR, 0=OR
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid & in_ready
- in_a  in  N  operand to array in1
- in_b  in  N  operand to array in2
- out_valid  out  1  result row valid
- out_ready  in  1  host accepts row
- out_data  out  N  result row
- out_last  out  1  marks row N-1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last row is accepted
- arr_clear  out  1  array accumulator clear, active high
- arr_in_valid  out  1  array advance/accumulate strobe
- arr_readout  out  1  array readout strobe
- arr_usexor  out  1  latched mode
- arr_in1  out  N  array in1 bus
- arr_in2  out  N  array in2 bus
- arr_out  in  N  array output bus

Behaviour:
- Reset (async): state=IDLE. Registered outputs clear: in_ready, out_valid, out_data, out_last, busy, done, arr_clear, arr_in_valid, arr_readout, arr_usexor, arr_in1, arr_in2 all 0. Counters clear.
- arr_in1 and arr_in2 are 0 whenever arr_in_valid is 0.
- IDLE: on start, latch k_len (0 becomes 1) and mode_xor, then go to CLEAR. A start in any other state is ignored.
- CLEAR, 1 cycle: arr_clear=1, then LOAD.
- LOAD:
  - in_ready=1.
  - Each handshake registers in_a/in_b onto arr_in1/arr_in2 with arr_in_valid=1 the next cycle.
  - With no handshake, arr_in_valid=0 and the array holds.
  - After the k-th handshake: in_ready drops the same cycle (combinational on the count), then DRAIN.
- DRAIN, DRAIN cycles: arr_in_valid=1, arr_in1=arr_in2=0, then PRIME.
- PRIME, 1 cycle: arr_readout=1 (array moves accumulators into its shift path); nothing is captured. Then READ, row=0.
- READ:
  - arr_readout=1 only when the output register is empty, or is being accepted (out_valid & out_ready) that cycle.
  - On such a cycle: capture arr_out into out_data, set out_valid=1, out_last=(row==N-1), row++.
  - Otherwise arr_readout=0 and the array holds, so backpressure loses no rows.
  - After capturing row N-1, go to WAIT.
- WAIT: when the final row is accepted, out_valid=0 and done=1 for one cycle, then IDLE. busy falls in the same cycle done rises.
- Rows appear in array order, row 0 first. Throughput is 1 row/cycle while out_ready is held high.
- Counters: pair count is 8 bits. DRAIN count is $clog2(DRAIN+1) bits. Row count is $clog2(N) bits with no wrap.
- Reset mid-job: returns to IDLE immediately. arr_clear is not pulsed; the next job's CLEAR cleans the array.
- in_valid held high across LOAD exit: exactly k pairs are consumed.

Optional Feature:
- Macro SEQ_SKEW_EN.
- Defined: a diagonal skew stage sits on arr_in1/arr_in2.
  - Bit i of in1 is delayed i cycles; bit j of in2 is delayed j cycles, using per-bit shift registers advanced only when arr_in_valid=1.
  - DRAIN is effectively raised by N-1 cycles so the skew flushes.
- Undefined: operands pass straight through; DRAIN is used as given.

Test Plan:
- Reset check: assert rst_n=0 mid-LOAD with k_len=4 after 2 pairs -> all outputs 0 on the same edge; busy=0; a following start runs a clean job.
- Single-pair OR job: k_len=1, mode_xor=0, in_a=8'hFF, in_b=8'h01 -> CLEAR pulse, 1 valid pair, 14 drain cycles, PRIME. Then 8 rows matching the array model; out_last on row 7; done one cycle later; busy low after.
- XOR cancellation: k_len=2, mode_xor=1, both pairs in_a=8'hA5, in_b=8'h3C -> all 8 rows 8'h00.
- k_len=0: treated as 1 -> exactly one pair accepted; in_ready low for the second presented pair.
- Backpressure: out_ready toggled 1,0,0,1 repeatedly -> arr_readout low on every held cycle; 8 rows delivered in order with no loss or duplication.
- Start ignored: start pulsed during LOAD and READ -> no state change; latched k_len and mode are unchanged.
